// File: rtl/ddr_sched_pkg.sv
// Shared DDR definitions: CBA word layout, command encodings, scheduler states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ddr_include;

  localparam int A_WIDTH   = 13;
  localparam int BA_WIDTH  = 2;
  localparam int CBA_WIDTH = 3 + BA_WIDTH + A_WIDTH;

  // {ras_n, cas_n, we_n}
  typedef logic [2:0] ddr_cmd_t;
  localparam ddr_cmd_t DDR_CMD_NOP   = 3'b111;
  localparam ddr_cmd_t DDR_CMD_ACT   = 3'b011;
  localparam ddr_cmd_t DDR_CMD_PRE   = 3'b010;
  localparam ddr_cmd_t DDR_CMD_AR    = 3'b001;
  localparam ddr_cmd_t DDR_CMD_READ  = 3'b101;
  localparam ddr_cmd_t DDR_CMD_WRITE = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE_ALL,
    ST_AREF,
    ST_PRE,
    ST_ACT,
    ST_RW,
    ST_ACK
  } sched_state_t;

  function automatic logic [CBA_WIDTH-1:0] cba_word(input ddr_cmd_t cmd,
                                                    input logic [BA_WIDTH-1:0] ba,
                                                    input logic [A_WIDTH-1:0] a);
    return {cmd, ba, a};
  endfunction

endpackage

// File: rtl/ddr_sched_if.sv
// Request and CBA FIFO write-port bundle between requester/FIFO (master) and scheduler (slave).
// Latency: n/a (wiring only).
// Backpressure: cba_full from the FIFO side gates cba_wr; req_valid is held until req_ack.
interface ddr_sched_if #(
  parameter int ADR_WIDTH = 25
);
  import ddr_include::*;

  logic                 req_valid;
  logic                 req_we;
  logic [ADR_WIDTH-1:0] req_adr;
  logic                 req_ack;
  logic [CBA_WIDTH-1:0] cba_din;
  logic                 cba_wr;
  logic                 cba_full;
  logic                 refresh_pending;

  modport master (
    output req_valid, req_we, req_adr, cba_full,
    input  req_ack, cba_din, cba_wr, refresh_pending
  );

  modport slave (
    input  req_valid, req_we, req_adr, cba_full,
    output req_ack, cba_din, cba_wr, refresh_pending
  );

endinterface

// File: rtl/ddr_sched_refresh_timer.sv
// Auto-refresh interval timer with a single owed-refresh flag.
// Latency: pending rises REFRESH_CYCLES cycles after init_done goes high, then every REFRESH_CYCLES.
// Backpressure: none; an expiry while already pending is absorbed.
module ddr_refresh_timer #(
  parameter int REFRESH_CYCLES = 780
) (
  input  logic clk,
  input  logic reset_n,
  input  logic init_done,
  input  logic clr,
  output logic pending
);
  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(REFRESH_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          expire;

  assign expire = init_done && (cnt == '0);

  // Countdown, parked at the reload value until the DDR init sequence is done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= RELOAD;
    end else if (!init_done || expire) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  // Owed-refresh flag; a fresh expiry wins over a clear landing in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
    end else if (expire) begin
      pending <= 1'b1;
    end else if (clr) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/ddr_sched.sv
// DDR command scheduler: turns read/write requests and periodic refresh into CBA FIFO words.
// Latency: closed-page ACT/RW/ack at +1/+2/+3 cycles after the request is sampled in IDLE.
// Backpressure: cba_wr = ~cba_full in push states; the FSM only advances on an accepted push.
// Optional: define DDR_OPEN_ROW_EN for the open-row policy; default is closed-page with auto-precharge.
module ddr_sched
  import ddr_include::*;
#(
  parameter int ROW_WIDTH      = 13,
  parameter int COL_WIDTH      = 10,
  parameter int REFRESH_CYCLES = 780
) (
  input logic        clk,
  input logic        reset_n,
  input logic        init_done,
  ddr_sched_if.slave bus
);
  localparam int A10   = 10;
  localparam int ADR_W = ROW_WIDTH + BA_WIDTH + COL_WIDTH;

  sched_state_t state, state_nxt, req_state;

  logic                 push_state;
  logic                 push;
  logic                 refresh_pending;
  logic                 take_req;
  logic                 rw_a10;
  logic                 lat_we;
  logic [ROW_WIDTH-1:0] lat_row;
  logic [BA_WIDTH-1:0]  lat_ba;
  logic [COL_WIDTH-1:0] lat_col;
  logic [ROW_WIDTH-1:0] adr_row;
  logic [BA_WIDTH-1:0]  adr_ba;
  logic [COL_WIDTH-1:0] adr_col;
  logic [A_WIDTH-1:0]   a_row;
  logic [A_WIDTH-1:0]   a_col;
  logic [A_WIDTH-1:0]   a_all;
  logic [CBA_WIDTH-1:0] din;

  assign adr_row  = bus.req_adr[ADR_W-1 -: ROW_WIDTH];
  assign adr_ba   = bus.req_adr[COL_WIDTH +: BA_WIDTH];
  assign adr_col  = bus.req_adr[COL_WIDTH-1:0];
  assign take_req = (state == ST_IDLE) && init_done && !refresh_pending && bus.req_valid;

  assign bus.refresh_pending = refresh_pending;

  ddr_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_refresh_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .init_done(init_done),
    .clr      (push && (state == ST_AREF)),
    .pending  (refresh_pending)
  );

`ifdef DDR_OPEN_ROW_EN
  logic [2**BA_WIDTH-1:0]                open_flag;
  logic [2**BA_WIDTH-1:0][ROW_WIDTH-1:0] open_row;

  // Per-bank open row: ACT opens it, the all-bank refresh closes every bank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      open_flag <= '0;
      open_row  <= '0;
    end else if (push && (state == ST_AREF)) begin
      open_flag <= '0;
    end else if (push && (state == ST_ACT)) begin
      open_flag[lat_ba] <= 1'b1;
      open_row[lat_ba]  <= lat_row;
    end
  end

  // Row hit skips straight to the column command; a conflicting open row is precharged first.
  always_comb begin
    req_state = ST_ACT;
    if (open_flag[adr_ba]) begin
      req_state = (open_row[adr_ba] == adr_row) ? ST_RW : ST_PRE;
    end
  end

  assign rw_a10 = 1'b0;
`else
  assign req_state = ST_ACT;
  assign rw_a10    = 1'b1;
`endif

  // Request capture at the moment the FSM leaves IDLE for a read/write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_we  <= 1'b0;
      lat_row <= '0;
      lat_ba  <= '0;
      lat_col <= '0;
    end else if (take_req) begin
      lat_we  <= bus.req_we;
      lat_row <= adr_row;
      lat_ba  <= adr_ba;
      lat_col <= adr_col;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: refresh beats requests in IDLE; push states wait for an accepted push.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (init_done && refresh_pending) begin
          state_nxt = ST_PRE_ALL;
        end else if (take_req) begin
          state_nxt = req_state;
        end
      end
      ST_PRE_ALL: if (push) state_nxt = ST_AREF;
      ST_AREF:    if (push) state_nxt = ST_IDLE;
      ST_PRE:     if (push) state_nxt = ST_ACT;
      ST_ACT:     if (push) state_nxt = ST_RW;
      ST_RW:      if (push) state_nxt = ST_ACK;
      ST_ACK:     state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: CBA word per state, push strobe gated by FIFO full, one-cycle ack.
  always_comb begin
    a_row                   = '0;
    a_row[ROW_WIDTH-1:0]    = lat_row;
    a_col                   = '0;
    a_col[COL_WIDTH-1:0]    = lat_col;
    a_col[A10]              = rw_a10;
    a_all                   = '0;
    a_all[A10]              = 1'b1;
    push_state              = 1'b1;
    din                     = cba_word(DDR_CMD_NOP, '0, '0);
    case (state)
      ST_PRE_ALL: din = cba_word(DDR_CMD_PRE, '0, a_all);
      ST_AREF:    din = cba_word(DDR_CMD_AR, '0, '0);
      ST_PRE:     din = cba_word(DDR_CMD_PRE, lat_ba, '0);
      ST_ACT:     din = cba_word(DDR_CMD_ACT, lat_ba, a_row);
      ST_RW:      din = cba_word(lat_we ? DDR_CMD_WRITE : DDR_CMD_READ, lat_ba, a_col);
      default:    push_state = 1'b0;
    endcase
    push        = push_state && !bus.cba_full;
    bus.cba_wr  = push;
    bus.cba_din = din;
    bus.req_ack = (state == ST_ACK);
  end

endmodule

// File: tb/tb_ddr_sched.sv
// Scoreboard bench for ddr_sched: stimulus queues expected CBA words/cycles and ack cycles,
// a negedge monitor pops and compares whenever the scheduler pushes or acks.
// Runs with REFRESH_CYCLES=20; sections restart from reset so refresh timing is known.
module tb_ddr_sched;

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_AR  = 3'b001;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;

`ifdef DDR_OPEN_ROW_EN
  localparam logic [12:0] AP = 13'h000;
`else
  localparam logic [12:0] AP = 13'h400;
`endif

  typedef struct {
    logic [17:0] w;
    int          c;
  } exp_t;

  logic clk;
  logic reset_n;
  logic init_done;
  int   cyc;
  int   total;
  int   bad;
  exp_t cq[$];
  int   aq[$];

  ddr_sched_if sif ();

  ddr_sched #(
    .ROW_WIDTH     (13),
    .COL_WIDTH     (10),
    .REFRESH_CYCLES(20)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .init_done(init_done),
    .bus      (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [17:0] cw(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a);
    return {c, b, a};
  endfunction

  function automatic logic [24:0] mk_adr(input logic [12:0] row, input logic [1:0] b, input logic [9:0] col);
    return {row, b, col};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: every push and every ack is matched against the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (reset_n === 1'b1 && sif.cba_wr === 1'b1) begin
      if (cq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected cba push: got %h at cycle %0d, required no push", sif.cba_din, cyc);
      end else begin
        e = cq.pop_front();
        chk("cba word", 32'(sif.cba_din), 32'(e.w));
        chk("cba cycle", 32'(cyc), 32'(e.c));
      end
    end
    if (reset_n === 1'b1 && sif.req_ack === 1'b1) begin
      if (aq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected req_ack: got ack at cycle %0d, required none", cyc);
      end else begin
        a = aq.pop_front();
        chk("req_ack cycle", 32'(cyc), 32'(a));
      end
    end
  end

  task automatic exp_push(input logic [17:0] w, input int c);
    exp_t e;
    e.w = w;
    e.c = c;
    cq.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_section(output int t0);
    sif.req_valid = 1'b0;
    sif.cba_full  = 1'b0;
    init_done     = 1'b0;
    reset_n       = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    init_done = 1'b1;
    t0        = cyc;
  endtask

  // Drive one request; expected pushes at t+d*, ack at t+dack; cba_full held for 'stall' cycles.
  task automatic issue(input logic we, input logic [24:0] adr, input int n,
                       input logic [17:0] e0, input logic [17:0] e1, input logic [17:0] e2,
                       input int d0, input int d1, input int d2, input int dack, input int stall);
    int t;
    bit seen;
    t = cyc;
    if (n > 0) exp_push(e0, t + d0);
    if (n > 1) exp_push(e1, t + d1);
    if (n > 2) exp_push(e2, t + d2);
    aq.push_back(t + dack);
    sif.req_we    = we;
    sif.req_adr   = adr;
    sif.req_valid = 1'b1;
    sif.cba_full  = (stall > 0);
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (cyc == t + stall + 1) sif.cba_full = 1'b0;
      if (sif.req_ack === 1'b1) seen = 1'b1;
    end
    sif.req_valid = 1'b0;
    sif.cba_full  = 1'b0;
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL req_ack timeout: no ack seen, required at cycle %0d", t + dack);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout: simulation still running at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int T;
    int t;
    cyc           = 0;
    total         = 0;
    bad           = 0;
    reset_n       = 1'b0;
    init_done     = 1'b0;
    sif.req_valid = 1'b0;
    sif.req_we    = 1'b0;
    sif.req_adr   = '0;
    sif.cba_full  = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("reset cba_wr", 32'(sif.cba_wr), 32'd0);
    chk("reset req_ack", 32'(sif.req_ack), 32'd0);
    chk("reset refresh_pending", 32'(sif.refresh_pending), 32'd0);
    chk("reset cba_din", 32'(sif.cba_din), 32'(cw(C_NOP, 2'd0, 13'd0)));
    reset_n = 1'b1;

    // init_done low: a request must not be served (monitor flags any push/ack).
    @(posedge clk);
    #1;
    sif.req_adr   = mk_adr(13'h001, 2'd0, 10'h000);
    sif.req_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    sif.req_valid = 1'b0;
    @(posedge clk);
    #1;

    // Idle refresh: PRE-all/AR at +21/+22 and every 20 cycles after.
    init_done = 1'b1;
    T = cyc;
    for (int k = 0; k < 3; k++) begin
      exp_push(cw(C_PRE, 2'd0, 13'h400), T + 21 + 20 * k);
      exp_push(cw(C_AR, 2'd0, 13'h000), T + 22 + 20 * k);
    end
    wait_to(T + 19);
    chk("pending before expiry", 32'(sif.refresh_pending), 32'd0);
    wait_to(T + 20);
    chk("pending at expiry", 32'(sif.refresh_pending), 32'd1);
    wait_to(T + 23);
    chk("pending after AR", 32'(sif.refresh_pending), 32'd0);
    wait_to(T + 64);

    // Write row 0x123 bank 2 col 0x010, then a read with cba_full held 5 cycles in ACT.
    start_section(T);
    wait_to(T + 2);
    issue(1'b1, mk_adr(13'h123, 2'd2, 10'h010), 2,
          cw(C_ACT, 2'd2, 13'h123), cw(C_WR, 2'd2, 13'h010 | AP), 18'd0, 1, 2, 0, 3, 0);
    issue(1'b0, mk_adr(13'h0AB, 2'd0, 10'h003), 2,
          cw(C_ACT, 2'd0, 13'h0AB), cw(C_RD, 2'd0, 13'h003 | AP), 18'd0, 6, 7, 0, 8, 5);

    // Three reads on bank 1: same row twice, then row 0x5.
    start_section(T);
    wait_to(T + 1);
    issue(1'b0, mk_adr(13'h077, 2'd1, 10'h005), 2,
          cw(C_ACT, 2'd1, 13'h077), cw(C_RD, 2'd1, 13'h005 | AP), 18'd0, 1, 2, 0, 3, 0);
`ifdef DDR_OPEN_ROW_EN
    issue(1'b0, mk_adr(13'h077, 2'd1, 10'h006), 1,
          cw(C_RD, 2'd1, 13'h006), 18'd0, 18'd0, 1, 0, 0, 2, 0);
    issue(1'b0, mk_adr(13'h005, 2'd1, 10'h007), 3,
          cw(C_PRE, 2'd1, 13'h000), cw(C_ACT, 2'd1, 13'h005), cw(C_RD, 2'd1, 13'h007), 1, 2, 3, 4, 0);
`else
    issue(1'b0, mk_adr(13'h077, 2'd1, 10'h006), 2,
          cw(C_ACT, 2'd1, 13'h077), cw(C_RD, 2'd1, 13'h406), 18'd0, 1, 2, 0, 3, 0);
    issue(1'b0, mk_adr(13'h005, 2'd1, 10'h007), 2,
          cw(C_ACT, 2'd1, 13'h005), cw(C_RD, 2'd1, 13'h407), 18'd0, 1, 2, 0, 3, 0);
`endif

    // Refresh expires while the write sits in RW: ack first, then PRE-all/AR, then ACT again.
    start_section(T);
    wait_to(T + 18);
    issue(1'b1, mk_adr(13'h1F0, 2'd3, 10'h3FF), 2,
          cw(C_ACT, 2'd3, 13'h1F0), cw(C_WR, 2'd3, 13'h3FF | AP), 18'd0, 1, 2, 0, 3, 0);
    exp_push(cw(C_PRE, 2'd0, 13'h400), T + 23);
    exp_push(cw(C_AR, 2'd0, 13'h000), T + 24);
    chk("pending held over request", 32'(sif.refresh_pending), 32'd1);
    wait_to(T + 25);
    chk("pending cleared by AR", 32'(sif.refresh_pending), 32'd0);
    issue(1'b1, mk_adr(13'h1F0, 2'd3, 10'h3FF), 2,
          cw(C_ACT, 2'd3, 13'h1F0), cw(C_WR, 2'd3, 13'h3FF | AP), 18'd0, 1, 2, 0, 3, 0);

    // Reset pulsed while in ACT: outputs drop immediately, open rows forgotten.
    start_section(T);
    wait_to(T + 1);
    issue(1'b0, mk_adr(13'h0C0, 2'd0, 10'h001), 2,
          cw(C_ACT, 2'd0, 13'h0C0), cw(C_RD, 2'd0, 13'h001 | AP), 18'd0, 1, 2, 0, 3, 0);
    sif.req_we    = 1'b1;
    sif.req_adr   = mk_adr(13'h0DD, 2'd2, 10'h002);
    sif.req_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("ACT before reset cba_wr", 32'(sif.cba_wr), 32'd1);
    chk("ACT before reset cba_din", 32'(sif.cba_din), 32'(cw(C_ACT, 2'd2, 13'h0DD)));
    #1;
    reset_n = 1'b0;
    #1;
    chk("async reset cba_wr", 32'(sif.cba_wr), 32'd0);
    chk("async reset cba_din", 32'(sif.cba_din), 32'(cw(C_NOP, 2'd0, 13'd0)));
    chk("async reset req_ack", 32'(sif.req_ack), 32'd0);
    sif.req_valid = 1'b0;
    init_done     = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    init_done = 1'b1;
    issue(1'b0, mk_adr(13'h0C0, 2'd0, 10'h001), 2,
          cw(C_ACT, 2'd0, 13'h0C0), cw(C_RD, 2'd0, 13'h001 | AP), 18'd0, 1, 2, 0, 3, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("pushes outstanding", 32'(cq.size()), 32'd0);
    chk("acks outstanding", 32'(aq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
